// File: rtl/disp_timing_ctrl.sv
// Raster timing (HSYNC/VSYNC/DE), sticky VBLANK flag and frame-buffer fetch address, advanced by PIXEN.
// Outputs registered, reflecting the raster position after the same edge; no backpressure, PIXEN=0 freezes the raster.
module disp_timing_ctrl #(
    parameter int H_ACTIVE     = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_ACTIVE     = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33,
    parameter int PIX_PER_WORD = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PIXEN,
    input  logic        CLRVBLNK,
    input  logic [29:0] DISPADDR,
    input  logic        DISPON,
    output logic        VBLANK,
    output logic        HSYNC,
    output logic        VSYNC,
    output logic        DE,
    output logic [29:0] FETCH_ADDR
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] PIX_MASK = HW'(PIX_PER_WORD - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0] h, h_nx;
    logic [VW-1:0] v, v_nx;
    logic          on_q, on_nx;
    logic          frame_start, vblank_set, leave_word;

    always_comb begin
        h_nx = h + 1'b1;
        v_nx = v;
        if (h == H_LAST) begin
            h_nx = '0;
            v_nx = (v == V_LAST) ? '0 : v + 1'b1;
        end
        frame_start = (h_nx == '0) && (v_nx == '0);
        vblank_set  = PIXEN && (h_nx == '0) && (v_nx == V_ACT);
        // Leaving the last pixel of a word inside the visible area bumps the address.
        leave_word  = (h < H_ACT) && (v < V_ACT) && ((h & PIX_MASK) == PIX_MASK);
        on_nx       = frame_start ? DISPON : on_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h          <= H_LAST;
            v          <= V_LAST;
            on_q       <= 1'b0;
            VBLANK     <= 1'b0;
            HSYNC      <= 1'b1;
            VSYNC      <= 1'b1;
            DE         <= 1'b0;
            FETCH_ADDR <= '0;
        end else begin
            // Clear has priority; a set event coinciding with it is dropped.
            if (CLRVBLNK)
                VBLANK <= 1'b0;
            else if (vblank_set)
                VBLANK <= 1'b1;

            if (PIXEN) begin
                h     <= h_nx;
                v     <= v_nx;
                on_q  <= on_nx;
                HSYNC <= !((h_nx >= HS_BEG) && (h_nx < HS_END));
                VSYNC <= !((v_nx >= VS_BEG) && (v_nx < VS_END));
                DE    <= on_nx && (h_nx < H_ACT) && (v_nx < V_ACT);
                if (frame_start)
                    FETCH_ADDR <= DISPADDR;
                else if (leave_word)
                    FETCH_ADDR <= FETCH_ADDR + 30'd1;
            end
        end
    end

endmodule

// File: tb/tb_disp_timing_ctrl.sv
// Scoreboard bench for disp_timing_ctrl: a linear-raster-index model pushes expected outputs,
// a monitor on the falling edge pops and compares them.
module tb_disp_timing_ctrl;

    localparam int HA = 4, HF = 1, HS = 1, HB = 1;
    localparam int VA = 3, VF = 1, VS = 1, VB = 1;
    localparam int PPW = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FR = HT * VT;
    localparam int N_RAND = 3000;

    logic        clk;
    logic        rst;
    logic        PIXEN;
    logic        CLRVBLNK;
    logic [29:0] DISPADDR;
    logic        DISPON;
    logic        VBLANK;
    logic        HSYNC;
    logic        VSYNC;
    logic        DE;
    logic [29:0] FETCH_ADDR;

    disp_timing_ctrl #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .PIX_PER_WORD(PPW)
    ) dut (
        .clk(clk), .rst(rst), .PIXEN(PIXEN), .CLRVBLNK(CLRVBLNK),
        .DISPADDR(DISPADDR), .DISPON(DISPON), .VBLANK(VBLANK),
        .HSYNC(HSYNC), .VSYNC(VSYNC), .DE(DE), .FETCH_ADDR(FETCH_ADDR)
    );

    typedef struct packed {
        logic        vblank;
        logic        hsync;
        logic        vsync;
        logic        de;
        logic [29:0] fa;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Reference state: position as a linear index into the frame.
    int          m_p;
    bit          m_started;
    logic [29:0] m_base;
    bit          m_on;
    bit          m_vb;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cyc %0d got %h want %h", name, cyc, got, want);
        end
    endtask

    function automatic exp_t model_out();
        int   h, v, cnt;
        exp_t e;
        h        = m_p % HT;
        v        = m_p / HT;
        e.vblank = m_vb;
        e.hsync  = !(h >= HA + HF && h < HA + HF + HS);
        e.vsync  = !(v >= VA + VF && v < VA + VF + VS);
        e.de     = m_on && h < HA && v < VA;
        if (v >= VA)      cnt = VA * HA;
        else if (h >= HA) cnt = (v + 1) * HA;
        else              cnt = v * HA + h;
        e.fa     = m_started ? m_base + 30'(cnt / PPW) : 30'd0;
        return e;
    endfunction

    task automatic model_reset();
        m_p       = FR - 1;
        m_started = 0;
        m_base    = '0;
        m_on      = 0;
        m_vb      = 0;
    endtask

    task automatic model_edge();
        if (!rst) return;
        if (CLRVBLNK) m_vb = 0;
        if (PIXEN) begin
            m_p = (m_p + 1) % FR;
            if (m_p == 0) begin
                m_started = 1;
                m_base    = DISPADDR;
                m_on      = DISPON;
            end
            if (m_p == VA * HT && !CLRVBLNK) m_vb = 1;
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("vblank", {31'd0, VBLANK}, {31'd0, e.vblank});
                chk("hsync",  {31'd0, HSYNC},  {31'd0, e.hsync});
                chk("vsync",  {31'd0, VSYNC},  {31'd0, e.vsync});
                chk("de",     {31'd0, DE},     {31'd0, e.de});
                chk("fetch",  {2'd0, FETCH_ADDR}, {2'd0, e.fa});
            end
        end
    end

    task automatic directed_inputs(input int c);
        if (c == 9)   begin DISPADDR = 30'h10426240; DISPON = 1'b0; end
        if (c == 24)  CLRVBLNK = 1'b1;
        if (c == 25)  CLRVBLNK = 1'b0;
        if (c == 104) CLRVBLNK = 1'b1;
        if (c == 107) CLRVBLNK = 1'b0;
        if (c == 110) PIXEN = 1'b0;
        if (c == 115) PIXEN = 1'b1;
        if (c == 120) rst = 1'b0;
        if (c == 123) begin rst = 1'b1; DISPADDR = 30'h1085557C; DISPON = 1'b1; end
    endtask

    task automatic directed_checks(input int c);
        case (c)
            1:   begin chk("f0_de", {31'd0, DE}, 32'd1); chk("f0_addr", {2'd0, FETCH_ADDR}, 32'h1085557C); end
            3:   chk("f0_addr_e3", {2'd0, FETCH_ADDR}, 32'h1085557D);
            5:   chk("de_h4", {31'd0, DE}, 32'd0);
            6:   chk("hsync_e6", {31'd0, HSYNC}, 32'd0);
            7:   chk("hsync_e7", {31'd0, HSYNC}, 32'd1);
            8:   chk("f0_addr_e8", {2'd0, FETCH_ADDR}, 32'h1085557E);
            21:  chk("vblank_e21", {31'd0, VBLANK}, 32'd0);
            22:  chk("vblank_e22", {31'd0, VBLANK}, 32'd1);
            25:  chk("vblank_clr", {31'd0, VBLANK}, 32'd0);
            29:  chk("vsync_e29", {31'd0, VSYNC}, 32'd0);
            36:  chk("vsync_e36", {31'd0, VSYNC}, 32'd1);
            43:  begin chk("f1_de", {31'd0, DE}, 32'd0); chk("f1_addr", {2'd0, FETCH_ADDR}, 32'h10426240); end
            106: chk("vblank_prio", {31'd0, VBLANK}, 32'd0);
            120: begin
                chk("rst_hsync", {31'd0, HSYNC}, 32'd1);
                chk("rst_vsync", {31'd0, VSYNC}, 32'd1);
                chk("rst_de", {31'd0, DE}, 32'd0);
                chk("rst_fetch", {2'd0, FETCH_ADDR}, 32'd0);
            end
            124: begin chk("rst_f0_de", {31'd0, DE}, 32'd1); chk("rst_f0_addr", {2'd0, FETCH_ADDR}, 32'h1085557C); end
            default: ;
        endcase
    endtask

    task automatic random_inputs();
        PIXEN    = ($urandom_range(0, 3) != 0);
        CLRVBLNK = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 39) == 0)
            DISPADDR = ($urandom_range(0, 1) == 0) ? 30'($urandom) : 30'h3FFFFFFC;
        if ($urandom_range(0, 39) == 0) DISPON = ~DISPON;
        if (!rst) rst = 1'b1;
        else if ($urandom_range(0, 499) == 0) rst = 1'b0;
    endtask

    initial begin
        logic rst_prev;
        rst      = 1'b0;
        PIXEN    = 1'b0;
        CLRVBLNK = 1'b0;
        DISPADDR = '0;
        DISPON   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        exp_q.push_back(model_out());
        DISPADDR = 30'h1085557C;
        DISPON   = 1'b1;
        PIXEN    = 1'b1;
        rst      = 1'b1;

        for (int c = 1; c <= 130 + N_RAND; c++) begin
            @(posedge clk);
            cyc = c;
            model_edge();
            #2;
            rst_prev = rst;
            if (c < 130) directed_inputs(c);
            else         random_inputs();
            if (rst_prev && !rst) model_reset();
            exp_q.push_back(model_out());
            #1;
            directed_checks(c);
        end

        @(negedge clk);
        #1;
        chk("drain", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/disp_timing_ctrl.md
# disp_timing_ctrl

Display-controller side of the display register handshake. It generates raster timing (HSYNC/VSYNC/DE) from a pixel-enable strobe and raises a sticky VBLANK flag at the start of vertical blanking, which the display master clears with CLRVBLNK. It samples DISPADDR/DISPON at each frame start and produces the frame-buffer word fetch address for the pixel pipeline.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, HSYNC pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels, ≥1)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, VSYNC pulse width (lines)
- V_BP, 33, vertical back porch (lines, ≥1)
- PIX_PER_WORD, 2, pixels per 32-bit frame-buffer word (power of two)

Ports:
- clk  in  1  single system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- PIXEN  in  1  pixel strobe; the raster advances one pixel on each clk edge where PIXEN=1
- CLRVBLNK  in  1  level clear of VBLANK
- DISPADDR  in  30  frame-buffer base word address
- DISPON  in  1  display enable
- VBLANK  out  1  sticky vertical-blank flag
- HSYNC  out  1  horizontal sync, active low
- VSYNC  out  1  vertical sync, active low
- DE  out  1  data enable, active pixel and display on
- FETCH_ADDR  out  30  word address of the current pixel

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. h counts 0..H_TOTAL-1; v counts 0..V_TOTAL-1.
- On a PIXEN edge: h increments. When h=H_TOTAL-1, h←0 and v increments. When v=V_TOTAL-1 at line end, v←0. Without PIXEN, counters and HSYNC/VSYNC/DE/FETCH_ADDR hold.
- Reset: h=H_TOTAL-1, v=V_TOTAL-1, HSYNC=1, VSYNC=1, DE=0, VBLANK=0, FETCH_ADDR=0, latched base=0, latched on=0. The first PIXEN edge is therefore a frame start.
- Frame start is the PIXEN edge entering (0,0):
  - latched base←DISPADDR, latched on←DISPON
  - FETCH_ADDR←DISPADDR
  - DISPADDR/DISPON changes mid-frame have no effect until the next frame start.
- All outputs are registered and reflect the position (h,v) held after the same edge:
  - HSYNC=0 iff H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC
  - VSYNC=0 iff V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC
  - DE=latched on ∧ h<H_ACTIVE ∧ v<V_ACTIVE
- FETCH_ADDR:
  - Increments by 1, modulo 2^30, on each PIXEN edge that leaves an active pixel whose (h+1) mod PIX_PER_WORD = 0.
  - Holds through blanking. Lines are contiguous: address = base + (v·H_ACTIVE+h)/PIX_PER_WORD.
  - Advances regardless of latched on.
- VBLANK:
  - Set event: the PIXEN edge entering (0,V_ACTIVE).
  - While CLRVBLNK=1, VBLANK←0 on every clk edge. Clear wins over a simultaneous set, and that set event is lost.
  - Otherwise a set event sets VBLANK, which stays 1 until cleared. The flag is set regardless of DISPON.
- Asynchronous reset asserted mid-frame returns all state to reset values immediately. No partial frame is resumed.

## Timing
- Flag latency: VBLANK reads 1 in the cycle after the set edge. The clear takes effect on the first clk edge with CLRVBLNK=1, one-cycle latency, independent of PIXEN.
- Frame latency: DISPADDR/DISPON sampled on the frame-start edge appear on DE/FETCH_ADDR in the same registered update.
- Sync pulses:
  - HSYNC low for exactly H_SYNC PIXEN edges per line.
  - VSYNC low for exactly V_SYNC·H_TOTAL PIXEN edges per frame.
- Single-frame behaviour: with PIXEN held high, one frame is H_TOTAL·V_TOTAL clk cycles.

## Test plan
All scenarios use small parameters, H=4/1/1/1 (H_TOTAL=7), V=3/1/1/1 (V_TOTAL=6), PIX_PER_WORD=2, PIXEN=1, and release reset with DISPADDR=0x1085557C, DISPON=1, CLRVBLNK=0.
- Frame start: after edge 1 -> DE=1, FETCH_ADDR=0x1085557C. Edge 3 -> FETCH_ADDR=0x1085557D. Edge 8 (line 1, h=0) -> FETCH_ADDR=0x1085557E. DE=0 at h=4..6.
- Sync: HSYNC=0 only after edges 6, 13, 20, …. VSYNC=0 after edges 29..35, and 1 again after edge 36.
- VBLANK handshake: VBLANK=0 through edge 21 and 1 after edge 22. With CLRVBLNK=1 for one cycle, VBLANK=0 the next cycle and stays 0 until edge 64.
- Clear priority: hold CLRVBLNK=1 across edge 22 -> VBLANK stays 0 for the whole frame.
- Frame latch: change DISPADDR to 0x10426240 and DISPON to 0 at edge 10 -> frame 1 is unaffected. From edge 43, DE=0 and FETCH_ADDR=0x10426240. HSYNC/VSYNC continue unchanged.
- PIXEN gating and reset: PIXEN=0 for 5 cycles mid-line -> all outputs frozen. Assert rst mid-frame -> immediately HSYNC=1, VSYNC=1, DE=0, VBLANK=0, FETCH_ADDR=0. After release, the first PIXEN edge is a frame start.
